// File: rtl/spu_pkg.sv
// Shared writeback/forwarding definitions: widths, staging depth, slot entry
// layout and the operand read-port indices.
package spu_pkg;
  localparam int DW    = 128;  // data width
  localparam int AW    = 7;    // register address width (128 entries)
  localparam int DEPTH = 7;    // staging slots per pipe, maximum latency
  localparam int LW    = 3;    // latency field width
  localparam int NRD   = 6;    // operand read ports

  // Read-port order: ra/rb/rc of the even pipe, then ra/rb/rc of the odd pipe.
  localparam int RA_E = 0;
  localparam int RB_E = 1;
  localparam int RC_E = 2;
  localparam int RA_O = 3;
  localparam int RB_O = 4;
  localparam int RC_O = 5;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_lane.sv
// One pipe's writeback staging lane. Slot k retires in k+1 cycles; slot 0 is
// the registered register-file write port. Flags are per-cycle pulses; the
// top level makes them sticky.
module wb_lane
  import spu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic [LW-1:0] lat_i,
  output wb_entry_t     slot_o [DEPTH],
  output logic          coll_o,
  output logic          lat_err_o
);

  wb_entry_t   slot_q [DEPTH];
  wb_entry_t   slot_d [DEPTH];
  int unsigned lat_u;

  // Shift every slot down one, then drop the new result into slot lat-1.
  // Whatever shifted into that slot is overwritten and reported as a collision.
  always_comb begin
    lat_u     = 32'(lat_i);
    lat_err_o = vld_i && (lat_u == 0 || lat_u > DEPTH);
    coll_o    = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) slot_d[k] = slot_q[k+1];
    slot_d[DEPTH-1] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld_i && !lat_err_o && lat_u == k + 1) begin
        coll_o    = slot_d[k].vld;
        slot_d[k] = '{vld: 1'b1, addr: addr_i, data: data_i};
      end
    end
  end

  // Slot state; reset discards everything in flight, data included.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/wb_forward.sv
// Writeback staging and operand forwarding for the even/odd pipes.
// Build option: define WB_FORWARD_EN to build the forwarding network; without
// it operands pass straight from the register file and no comparators exist.
// Widths must match spu_pkg, which sizes the slot entries.
module wb_forward
  import spu_pkg::*;
#(
  parameter int DW    = spu_pkg::DW,
  parameter int AW    = spu_pkg::AW,
  parameter int DEPTH = spu_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          res_even_vld,
  input  logic [DW-1:0] res_even_data,
  input  logic [AW-1:0] res_even_addr,
  input  logic [2:0]    res_even_lat,
  input  logic          res_odd_vld,
  input  logic [DW-1:0] res_odd_data,
  input  logic [AW-1:0] res_odd_addr,
  input  logic [2:0]    res_odd_lat,
  output logic [DW-1:0] data_even,
  output logic          wr_even,
  output logic [AW-1:0] addr_even,
  output logic [DW-1:0] data_odd,
  output logic          wr_odd,
  output logic [AW-1:0] addr_odd,
  input  logic [AW-1:0] rd_addr [NRD],
  input  logic [DW-1:0] rf_data [NRD],
  output logic [DW-1:0] op_data [NRD],
  output logic [NRD-1:0] fwd_hit,
  output logic          coll_err,
  output logic          lat_err
);

  wb_entry_t slot_e [DEPTH];
  wb_entry_t slot_o [DEPTH];
  logic      coll_e, coll_o, laterr_e, laterr_o;
  logic      coll_err_q, coll_err_d, lat_err_q, lat_err_d;

  wb_lane u_lane_even (
    .clk(clk), .reset(reset),
    .vld_i(res_even_vld), .addr_i(res_even_addr), .data_i(res_even_data),
    .lat_i(res_even_lat), .slot_o(slot_e), .coll_o(coll_e), .lat_err_o(laterr_e)
  );

  wb_lane u_lane_odd (
    .clk(clk), .reset(reset),
    .vld_i(res_odd_vld), .addr_i(res_odd_addr), .data_i(res_odd_data),
    .lat_i(res_odd_lat), .slot_o(slot_o), .coll_o(coll_o), .lat_err_o(laterr_o)
  );

  // Slot 0 of each lane is the registered write port.
  assign wr_even   = slot_e[0].vld;
  assign addr_even = slot_e[0].addr;
  assign data_even = slot_e[0].data;
  assign wr_odd    = slot_o[0].vld;
  assign addr_odd  = slot_o[0].addr;
  assign data_odd  = slot_o[0].data;

  // Error flags accumulate until reset.
  always_comb begin
    coll_err_d = coll_err_q | coll_e | coll_o;
    lat_err_d  = lat_err_q | laterr_e | laterr_o;
  end

  // Sticky error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      coll_err_q <= 1'b0;
      lat_err_q  <= 1'b0;
    end else begin
      coll_err_q <= coll_err_d;
      lat_err_q  <= lat_err_d;
    end
  end

  assign coll_err = coll_err_q;
  assign lat_err  = lat_err_q;

`ifdef WB_FORWARD_EN
  // Forward mux: scan slots from fewest to most remaining cycles, even before
  // odd, so the last match (youngest value, odd on a tie) wins.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      op_data[p] = rf_data[p];
      fwd_hit[p] = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_e[k].vld && slot_e[k].addr == rd_addr[p]) begin
          op_data[p] = slot_e[k].data;
          fwd_hit[p] = 1'b1;
        end
        if (slot_o[k].vld && slot_o[k].addr == rd_addr[p]) begin
          op_data[p] = slot_o[k].data;
          fwd_hit[p] = 1'b1;
        end
      end
    end
  end
`else
  logic unused_fwd;

  // No forwarding: operands come straight from the register file.
  always_comb begin
    fwd_hit    = '0;
    unused_fwd = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      op_data[p] = rf_data[p];
      unused_fwd = unused_fwd ^ (^rd_addr[p]);
    end
    for (int k = 1; k < DEPTH; k++) unused_fwd = unused_fwd ^ (^slot_e[k]) ^ (^slot_o[k]);
  end
`endif

endmodule

// File: tb/tb_wb_forward.sv
// Directed bench for wb_forward: staging latency, forwarding priority,
// simultaneous retire, collision/latency errors and mid-flight reset.
module tb_wb_forward;
  import spu_pkg::*;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          res_even_vld, res_odd_vld;
  logic [DW-1:0] res_even_data, res_odd_data;
  logic [AW-1:0] res_even_addr, res_odd_addr;
  logic [2:0]    res_even_lat, res_odd_lat;
  logic [DW-1:0] data_even, data_odd;
  logic          wr_even, wr_odd;
  logic [AW-1:0] addr_even, addr_odd;
  logic [AW-1:0] rd_addr [NRD];
  logic [DW-1:0] rf_data [NRD];
  logic [DW-1:0] op_data [NRD];
  logic [NRD-1:0] fwd_hit;
  logic          coll_err, lat_err;

  int vecs = 0;
  int errs = 0;

  wb_forward dut (
    .clk(clk), .reset(reset),
    .res_even_vld(res_even_vld), .res_even_data(res_even_data),
    .res_even_addr(res_even_addr), .res_even_lat(res_even_lat),
    .res_odd_vld(res_odd_vld), .res_odd_data(res_odd_data),
    .res_odd_addr(res_odd_addr), .res_odd_lat(res_odd_lat),
    .data_even(data_even), .wr_even(wr_even), .addr_even(addr_even),
    .data_odd(data_odd), .wr_odd(wr_odd), .addr_odd(addr_odd),
    .rd_addr(rd_addr), .rf_data(rf_data), .op_data(op_data),
    .fwd_hit(fwd_hit), .coll_err(coll_err), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset = 1'b0;
    res_even_vld = 1'b0; res_even_data = '0; res_even_addr = '0; res_even_lat = '0;
    res_odd_vld  = 1'b0; res_odd_data  = '0; res_odd_addr  = '0; res_odd_lat  = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_addr[p] = 7'h7F;
      rf_data[p] = 128'h1234;
    end
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    tick(); tick();
    #1;
    vecs++; if (wr_even !== 1'b0) begin errs++; $display("FAIL reset_wr_even got %b want 0", wr_even); end
    vecs++; if (wr_odd !== 1'b0) begin errs++; $display("FAIL reset_wr_odd got %b want 0", wr_odd); end
    vecs++; if (data_even !== '0 || addr_even !== '0) begin errs++; $display("FAIL reset_even_port got %0h/%0h want 0/0", data_even, addr_even); end
    vecs++; if (data_odd !== '0 || addr_odd !== '0) begin errs++; $display("FAIL reset_odd_port got %0h/%0h want 0/0", data_odd, addr_odd); end
    vecs++; if (coll_err !== 1'b0 || lat_err !== 1'b0) begin errs++; $display("FAIL reset_flags got %b%b want 00", coll_err, lat_err); end
    vecs++; if (fwd_hit !== 6'b0 || op_data[2] !== 128'h1234) begin errs++; $display("FAIL reset_fwd got %b/%0h want 0/1234", fwd_hit, op_data[2]); end
    reset = 1'b0;
  endtask

  // Even addr 5, data AA, lat 3: retires in cycle 3, forwarded cycles 1-3.
  task automatic test_latency();
    logic          ew, eh;
    logic [DW-1:0] ed;
    tick(); clr();
    for (int p = 0; p < NRD; p++) rd_addr[p] = 7'd5;
    res_even_vld = 1'b1; res_even_addr = 7'd5; res_even_data = 128'hAA; res_even_lat = 3'd3;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin tick(); res_even_vld = 1'b0; end
      #1;
      ew = (c == 3);
      eh = FWD && c >= 1 && c <= 3;
      ed = eh ? 128'hAA : 128'h1234;
      vecs++; if (wr_even !== ew) begin errs++; $display("FAIL lat_wr_even c%0d got %b want %b", c, wr_even, ew); end
      vecs++; if (wr_odd !== 1'b0) begin errs++; $display("FAIL lat_wr_odd c%0d got %b want 0", c, wr_odd); end
      if (c == 3) begin
        vecs++; if (addr_even !== 7'd5 || data_even !== 128'hAA) begin errs++; $display("FAIL lat_port c%0d got %0h/%0h want 5/aa", c, addr_even, data_even); end
      end
      vecs++; if (op_data[RA_E] !== ed || fwd_hit[RA_E] !== eh) begin errs++; $display("FAIL lat_fwd0 c%0d got %0h/%b want %0h/%b", c, op_data[RA_E], fwd_hit[RA_E], ed, eh); end
      vecs++; if (op_data[RB_O] !== ed || fwd_hit[RB_O] !== eh) begin errs++; $display("FAIL lat_fwd4 c%0d got %0h/%b want %0h/%b", c, op_data[RB_O], fwd_hit[RB_O], ed, eh); end
    end
  endtask

  // Even addr 9 lat 5 (cycle 0) and odd addr 9 lat 2 (cycle 1): even is the
  // later writer so it wins forwarding; odd retires c3, even c5.
  task automatic test_priority();
    logic          eh;
    logic [DW-1:0] ed;
    tick(); clr();
    rd_addr[RA_E] = 7'd9; rd_addr[RA_O] = 7'd9;
    res_even_vld = 1'b1; res_even_addr = 7'd9; res_even_data = 128'd1; res_even_lat = 3'd5;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        tick(); res_even_vld = 1'b0;
        res_odd_vld = 1'b1; res_odd_addr = 7'd9; res_odd_data = 128'd2; res_odd_lat = 3'd2;
      end else if (c > 1) begin
        tick(); res_odd_vld = 1'b0;
      end
      #1;
      eh = FWD && c >= 1 && c <= 5;
      ed = eh ? 128'd1 : 128'h1234;
      vecs++; if (wr_odd !== (c == 3)) begin errs++; $display("FAIL pri_wr_odd c%0d got %b want %b", c, wr_odd, c == 3); end
      vecs++; if (wr_even !== (c == 5)) begin errs++; $display("FAIL pri_wr_even c%0d got %b want %b", c, wr_even, c == 5); end
      if (c == 3) begin
        vecs++; if (addr_odd !== 7'd9 || data_odd !== 128'd2) begin errs++; $display("FAIL pri_odd_port got %0h/%0h want 9/2", addr_odd, data_odd); end
      end
      if (c == 5) begin
        vecs++; if (addr_even !== 7'd9 || data_even !== 128'd1) begin errs++; $display("FAIL pri_even_port got %0h/%0h want 9/1", addr_even, data_even); end
      end
      vecs++; if (op_data[RA_E] !== ed || fwd_hit[RA_E] !== eh) begin errs++; $display("FAIL pri_fwd c%0d got %0h/%b want %0h/%b", c, op_data[RA_E], fwd_hit[RA_E], ed, eh); end
      vecs++; if (op_data[RA_O] !== ed) begin errs++; $display("FAIL pri_fwd3 c%0d got %0h want %0h", c, op_data[RA_O], ed); end
    end
  endtask

  // Both lanes retire addr 4 together: both write, read of 4 forwards odd's 7.
  task automatic test_same_retire();
    logic [DW-1:0] ed;
    tick(); clr();
    rd_addr[RB_E] = 7'd4;
    res_even_vld = 1'b1; res_even_addr = 7'd4; res_even_data = 128'd3; res_even_lat = 3'd2;
    res_odd_vld  = 1'b1; res_odd_addr  = 7'd4; res_odd_data  = 128'd7; res_odd_lat  = 3'd2;
    tick(); res_even_vld = 1'b0; res_odd_vld = 1'b0;
    tick();
    #1;
    ed = FWD ? 128'd7 : 128'h1234;
    vecs++; if (wr_even !== 1'b1 || wr_odd !== 1'b1) begin errs++; $display("FAIL same_wr got %b%b want 11", wr_even, wr_odd); end
    vecs++; if (data_even !== 128'd3 || data_odd !== 128'd7) begin errs++; $display("FAIL same_data got %0h/%0h want 3/7", data_even, data_odd); end
    vecs++; if (addr_even !== 7'd4 || addr_odd !== 7'd4) begin errs++; $display("FAIL same_addr got %0h/%0h want 4/4", addr_even, addr_odd); end
    vecs++; if (op_data[RB_E] !== ed || fwd_hit[RB_E] !== FWD) begin errs++; $display("FAIL same_fwd got %0h/%b want %0h/%b", op_data[RB_E], fwd_hit[RB_E], ed, FWD); end
  endtask

  // Even lat 2 then even lat 1: second overwrites first at slot 0.
  task automatic test_collision();
    tick(); clr();
    #1;
    vecs++; if (coll_err !== 1'b0) begin errs++; $display("FAIL coll_pre got %b want 0", coll_err); end
    res_even_vld = 1'b1; res_even_addr = 7'd10; res_even_data = 128'h11; res_even_lat = 3'd2;
    tick();
    res_even_addr = 7'd11; res_even_data = 128'h22; res_even_lat = 3'd1;
    tick(); res_even_vld = 1'b0;
    #1;
    vecs++; if (coll_err !== 1'b1) begin errs++; $display("FAIL coll_flag got %b want 1", coll_err); end
    vecs++; if (wr_even !== 1'b1 || addr_even !== 7'd11 || data_even !== 128'h22) begin errs++; $display("FAIL coll_retire got %b/%0h/%0h want 1/b/22", wr_even, addr_even, data_even); end
    vecs++; if (lat_err !== 1'b0) begin errs++; $display("FAIL coll_laterr got %b want 0", lat_err); end
    tick();
    vecs++; if (wr_even !== 1'b0 || coll_err !== 1'b1) begin errs++; $display("FAIL coll_after got %b/%b want 0/1", wr_even, coll_err); end
  endtask

  // Latency 0 is dropped and flagged.
  task automatic test_lat_err();
    tick(); clr();
    res_odd_vld = 1'b1; res_odd_addr = 7'd2; res_odd_data = 128'h55; res_odd_lat = 3'd0;
    rd_addr[RC_O] = 7'd2;
    tick(); res_odd_vld = 1'b0;
    for (int c = 1; c < 4; c++) begin
      if (c > 1) tick();
      #1;
      vecs++; if (lat_err !== 1'b1) begin errs++; $display("FAIL laterr_flag c%0d got %b want 1", c, lat_err); end
      vecs++; if (wr_odd !== 1'b0 || wr_even !== 1'b0) begin errs++; $display("FAIL laterr_wr c%0d got %b%b want 00", c, wr_even, wr_odd); end
      vecs++; if (fwd_hit[RC_O] !== 1'b0) begin errs++; $display("FAIL laterr_fwd c%0d got %b want 0", c, fwd_hit[RC_O]); end
    end
  endtask

  // Reset with three entries staged discards them and clears the flags.
  task automatic test_reset_mid();
    tick(); clr();
    rd_addr[RA_E] = 7'd1; rd_addr[RA_O] = 7'd3;
    res_even_vld = 1'b1; res_even_addr = 7'd1; res_even_data = 128'h10; res_even_lat = 3'd4;
    res_odd_vld  = 1'b1; res_odd_addr  = 7'd2; res_odd_data  = 128'h20; res_odd_lat  = 3'd4;
    tick();
    res_odd_vld = 1'b0;
    res_even_addr = 7'd3; res_even_data = 128'h30; res_even_lat = 3'd3;
    reset = 1'b1;
    #1;
    vecs++; if (fwd_hit[RA_E] !== FWD) begin errs++; $display("FAIL rmid_staged got %b want %b", fwd_hit[RA_E], FWD); end
    tick();
    reset = 1'b0; res_even_vld = 1'b0;
    for (int c = 2; c < 7; c++) begin
      if (c > 2) tick();
      #1;
      vecs++; if (wr_even !== 1'b0 || wr_odd !== 1'b0) begin errs++; $display("FAIL rmid_wr c%0d got %b%b want 00", c, wr_even, wr_odd); end
      vecs++; if (data_even !== '0 || addr_even !== '0 || data_odd !== '0 || addr_odd !== '0) begin errs++; $display("FAIL rmid_port c%0d got %0h/%0h/%0h/%0h want 0", c, data_even, addr_even, data_odd, addr_odd); end
      vecs++; if (coll_err !== 1'b0 || lat_err !== 1'b0) begin errs++; $display("FAIL rmid_flags c%0d got %b%b want 00", c, coll_err, lat_err); end
      vecs++; if (fwd_hit !== 6'b0 || op_data[RA_O] !== 128'h1234) begin errs++; $display("FAIL rmid_fwd c%0d got %b/%0h want 0/1234", c, fwd_hit, op_data[RA_O]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_priority();
    test_same_retire();
    test_collision();
    test_lat_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wb_forward.md
# wb_forward

Writeback staging and operand-forwarding stage between the even/odd execution pipes and the 128-entry register file. Each pipe hands over a result with its unit latency. The block holds the result in a per-pipe staging shift register and retires it to the register file write ports exactly that many cycles later. The same staged results are forwarded onto the six operand-read buses, so dependent instructions see values that are not yet written.

## Interface
Parameters:
- DW, 128, data width
- AW, 7, register address width
- DEPTH, 7, staging stages per pipe; maximum legal latency

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- res_even_vld / res_odd_vld  in  1  result presented this cycle
- res_even_data / res_odd_data  in  DW  result value
- res_even_addr / res_odd_addr  in  AW  destination register
- res_even_lat / res_odd_lat  in  3  cycles until retire, legal 1..DEPTH
- data_even / data_odd  out  DW  register file write data
- wr_even / wr_odd  out  1  register file write enable
- addr_even / addr_odd  out  AW  register file write address
- rd_addr[0..5]  in  AW  operand addresses: ra/rb/rc even, then ra/rb/rc odd
- rf_data[0..5]  in  DW  raw register file read data for the same addresses
- op_data[0..5]  out  DW  operand data after forwarding
- fwd_hit  out  6  per-port forward indicator
- coll_err / lat_err  out  1  sticky error flags

## Operation
- Each pipe has its own lane of DEPTH slots. Slot k holds {vld, addr, data} and has k+1 cycles remaining.
- Every cycle, all slots shift down by one. Slot 0 drives the write outputs.
- A result with latency L is written into slot L-1. wr_* asserts exactly L cycles after the result is sampled.
- Latency 0 or latency > DEPTH: the result is dropped and lat_err sets.
- Collision: an existing entry shifts into the slot a new result targets. The new entry overwrites it and coll_err sets.
- Error flags stay set until reset.
- Forwarding, combinational for each read port p:
  - Compare rd_addr[p] against every valid slot in both lanes, including the current write outputs.
  - A result being inserted this cycle is not visible.
  - On multiple matches, the entry with the most remaining cycles wins.
  - On a tie between lanes, odd wins, matching the register file's write order.
  - With no match, op_data[p] = rf_data[p] and fwd_hit[p] = 0.
- Writing register 0 is permitted; there is no special case for it.

## Timing
- Reset, sampled at an edge: all slot valids clear, wr_*/data_*/addr_* = 0, error flags = 0.
- Reset asserted mid-operation discards in-flight results; none are retired.
- The write outputs are registered. The register file commits them on the next edge.
- The forward path from rd_addr, rf_data and slot state to op_data is combinational, zero latency.
- Both lanes retiring to the same address in the same cycle: both wr_* assert; no arbitration happens in this block.
- Throughput: one result per lane per cycle.

## Configuration
- WB_FORWARD_EN defined: the forwarding network is built as described above.
- WB_FORWARD_EN undefined:
  - op_data[p] = rf_data[p] and fwd_hit = 0.
  - Staging, retire and error behaviour are unchanged.
  - No comparators are synthesized.

## Structure
- Shared package spu_pkg holds:
  - DW, AW, DEPTH
  - typedef wb_entry_t {vld, addr, data}
  - the read-port index constants RA_E..RC_O
- Sub-module wb_lane, instantiated once per pipe:
  - holds the slot shift register, insert logic, collision and latency checks
  - exports its slot array for the forwarding mux in the top level

## Test plan
- Even result addr 5, data 0xAA, lat 3 at cycle 0 -> wr_even=1, addr_even=5, data_even=0xAA in cycle 3 only; wr_even=0 in cycles 1-2 and 4.
- rd_addr[0]=5 during cycles 1-3 of the same result -> op_data[0]=0xAA, fwd_hit[0]=1. In cycle 0 and cycle 4 it passes rf_data[0].
- Even addr 9 data 1 lat 5 at cycle 0, odd addr 9 data 2 lat 2 at cycle 1 -> a read of 9 in cycles 2-3 returns 1 (even retires last). In cycle 3 odd retires 2, and in cycle 5 even retires 1.
- Both lanes retire addr 4 in the same cycle with data 3 (even) and 7 (odd) -> a read of 4 in that cycle forwards 7.
- Even lat 2 at cycle 0, then even lat 1 at cycle 1 -> coll_err=1, retire in cycle 2 carries the second result. Lat 0 input -> lat_err=1, no write.
- Reset asserted in cycle 1 with three entries staged -> no wr_* asserts afterwards, all outputs 0, flags clear.
